// File: rtl/calc1_port_sched_if.sv
// calc1_port_sched_if: client request/response bus plus the calc1 port
// signals used by calc1_port_sched. "slave" is the scheduler side and
// "master" is the client/calc1 side.
interface calc1_port_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_cmd;
  logic [32*NUM_REQ-1:0] req_op1;
  logic [32*NUM_REQ-1:0] req_op2;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [1:0]            rsp_resp;
  logic [31:0]           rsp_data;
  logic [3:0]            calc_cmd_out;
  logic [31:0]           calc_data_out;
  logic [1:0]            calc_resp_in;
  logic [31:0]           calc_data_in;

  modport slave (
    input  req_valid, req_cmd, req_op1, req_op2, calc_resp_in, calc_data_in,
    output req_ready, rsp_valid, rsp_resp, rsp_data, calc_cmd_out, calc_data_out
  );

  modport master (
    output req_valid, req_cmd, req_op1, req_op2, calc_resp_in, calc_data_in,
    input  req_ready, rsp_valid, rsp_resp, rsp_data, calc_cmd_out, calc_data_out
  );
endinterface

// File: rtl/calc1_port_sched.sv
// calc1_port_sched: round-robin scheduler sharing one calc1 request port
// among NUM_REQ clients. One operation is in flight at a time; a WAIT-state
// timeout returns response code 2'b11 with zero data.
// Optional statistics counters are built when CALC1_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate, pulse req_ready to the winner and latch its operation
// CMD   | drive latched cmd and op1 to calc1
// OP2   | drive op2 to calc1, clear the timeout counter
// WAIT  | wait for calc1 response or timeout
// DONE  | pulse rsp_valid to the owning client with the latched result
module calc1_port_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                c_clk,
  input  logic                reset,
  calc1_port_sched_if.slave   bus
`ifdef CALC1_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]    stat_done,
  output logic [CNT_W-1:0]    stat_err
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] OP2  = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_q;
  logic [3:0]       cmd_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [TO_W-1:0]  to_cnt;
  logic [1:0]       resp_q;
  logic [31:0]      data_q;

  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] grant;
  logic             found;
  logic             accept;

  // Pick the first valid client at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = idx[IDX_W-1:0];
      end
    end
  end

  // Accept is suppressed while reset is held so no client sees a stray pulse.
  assign accept = (state == IDLE) && found && reset;

  // Output decode: everything is zero unless the state owns that output.
  always_comb begin
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.rsp_resp      = 2'b00;
    bus.rsp_data      = 32'h0;
    bus.calc_cmd_out  = 4'h0;
    bus.calc_data_out = 32'h0;
    if (accept) bus.req_ready[grant] = 1'b1;
    case (state)
      CMD: begin
        bus.calc_cmd_out  = cmd_q;
        bus.calc_data_out = op1_q;
      end
      OP2: bus.calc_data_out = op2_q;
      DONE: begin
        bus.rsp_valid[grant_q] = 1'b1;
        bus.rsp_resp           = resp_q;
        bus.rsp_data           = data_q;
      end
      default: ;
    endcase
  end

  // Scheduler FSM and operation/result registers.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      cmd_q   <= 4'h0;
      op1_q   <= 32'h0;
      op2_q   <= 32'h0;
      to_cnt  <= '0;
      resp_q  <= 2'b00;
      data_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_q <= grant;
            cmd_q   <= bus.req_cmd[4*grant +: 4];
            op1_q   <= bus.req_op1[32*grant +: 32];
            op2_q   <= bus.req_op2[32*grant +: 32];
            rr_ptr  <= (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
            state   <= CMD;
          end
        end
        CMD: state <= OP2;
        OP2: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (bus.calc_resp_in != 2'b00) begin
            resp_q <= bus.calc_resp_in;
            data_q <= bus.calc_data_in;
            state  <= DONE;
          end else if (to_cnt == TO_W'(TIMEOUT-1)) begin
            resp_q <= 2'b11;
            data_q <= 32'h0;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC1_SCHED_STATS_EN
  // Saturating completion and error counters; error means resp 2 or 3.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      stat_done <= '0;
      stat_err  <= '0;
    end else if (state == DONE) begin
      if (stat_done != '1) stat_done <= stat_done + 1'b1;
      if (resp_q[1] && (stat_err != '1)) stat_err <= stat_err + 1'b1;
    end
  end
`endif

endmodule

// File: doc/calc1_port_sched.md
Name: calc1_port_sched

Overview:
- Round-robin scheduler that shares one calc1 request port among NUM_REQ client requesters.
- Each client hands over a complete operation (cmd, operand1, operand2) in one handshake.
- The block then sequences calc1's two-cycle request protocol, waits for the response (bounded by a timeout) and returns resp/data to the owning client.
- Sits between the client logic and one calc1 port (reqN_cmd_in/reqN_data_in, out_respN/out_dataN).

Parameters:
- NUM_REQ, 4, number of client requesters (2..8).
- TIMEOUT, 64, WAIT-state cycle limit before a timeout response is generated (>=2).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- c_clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i: client i presents an operation.
- req_ready  output  NUM_REQ  bit i: one-cycle accept pulse to client i.
- req_cmd  input  4*NUM_REQ  client i command at bits [4i +: 4].
- req_op1  input  32*NUM_REQ  client i operand1 at bits [32i +: 32].
- req_op2  input  32*NUM_REQ  client i operand2 at bits [32i +: 32].
- rsp_valid  output  NUM_REQ  bit i: one-cycle response pulse to client i.
- rsp_resp  output  2  response code; qualified by rsp_valid.
- rsp_data  output  32  result data; qualified by rsp_valid.
- calc_cmd_out  output  4  drives calc1 reqN_cmd_in.
- calc_data_out  output  32  drives calc1 reqN_data_in.
- calc_resp_in  input  2  from calc1 out_respN.
- calc_data_in  input  32  from calc1 out_dataN.

Behaviour:
- Reset (reset==0 at a clock edge) clears every output and register to 0: state=IDLE, rr pointer=0, timeout counter=0.
- Reset overrides all other activity, including mid-operation; an in-flight op is dropped with no rsp_valid.
- FSM IDLE:
  - If any req_valid is set, grant the first valid index at or after the rr pointer (wrapping NUM_REQ-1 -> 0).
  - Pulse req_ready[grant] for that cycle and latch cmd/op1/op2 and the grant index.
  - Set rr pointer = grant+1 mod NUM_REQ; go to CMD.
  - If no req_valid is set, stay in IDLE with all outputs 0.
- CMD (1 cycle): calc_cmd_out=latched cmd, calc_data_out=op1; go to OP2.
- OP2 (1 cycle): calc_cmd_out=0, calc_data_out=op2; clear the timeout counter; go to WAIT.
- WAIT:
  - Drive calc_cmd_out=0 and calc_data_out=0; increment the timeout counter every cycle.
  - If calc_resp_in!=0, latch calc_resp_in/calc_data_in and go to DONE.
  - Else, if the counter reaches TIMEOUT-1, latch resp=2'b11, data=0 and go to DONE.
  - A response arriving on the same cycle as the timeout wins.
- DONE (1 cycle): rsp_valid[grant]=1, rsp_resp/rsp_data = latched values; go to IDLE.
  - rsp_resp/rsp_data read 0 whenever no rsp_valid bit is set.
- Exactly one operation is in flight; req_ready is never asserted outside IDLE.
- Latency:
  - Accept in cycle T; CMD at T+1; OP2 at T+2; WAIT from T+3.
  - A response sampled in cycle R gives rsp_valid at R+1.
  - Back-to-back ops: earliest next accept is the cycle after DONE.
- Response codes 0..2 pass through unchanged; 2'b11 (unused by calc1) is reserved for timeout.
- Commands are not checked; invalid commands go to calc1, which reports them.
- A client that drops req_valid before its req_ready pulse is simply not granted.

Optional Feature:
- Macro CALC1_SCHED_STATS_EN.
- When defined, adds output stat_done (CNT_W) and output stat_err (CNT_W):
  - stat_done increments on every DONE.
  - stat_err increments on DONE with resp==2 or resp==3.
  - Both saturate at all-ones and clear on reset.
- When undefined, neither port exists and no counter logic is built.

Test Plan:
- Add: client0 cmd=1, op1=0000_0001, op2=01FF_FFFF -> calc1 sees cmd 1/data 1, then cmd 0/data 01FF_FFFF; rsp_valid[0] with resp=1, data=0200_0000.
- All four clients request in the same cycle after reset -> grants in order 0,1,2,3, one op in flight at a time, each rsp_valid only on its own index.
- Fairness: clients 0 and 2 assert req_valid continuously -> grants alternate 0,2,0,2; client 0 is never granted twice in a row.
- Overflow: cmd=1, op1=FFFF_FFFF, op2=0000_0001 -> resp=2 passed through to the owning client.
- Timeout: calc_resp_in held 0 -> rsp_valid exactly TIMEOUT+1 cycles after OP2, resp=3, data=0. With CALC1_SCHED_STATS_EN: stat_err=1.
- Reset asserted during WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid for the dropped op; a new request is accepted normally starting from client 0.
